// File: rtl/h_timing_gen.sv
// ---------------------------------------------------------------------------
// h_timing_gen
// Horizontal timing generator for the VGA display path. Divides the system
// clock into VGA pixel periods and walks each line through the ACTIVE,
// FRONT porch, SYNC and BACK porch phases.
//
// Ports:
//   clk       in   system clock, all state changes on the rising edge
//   reset     in   synchronous, active-high reset
//   count     out  5-bit memory-pixel phase (0..REP-1 in ACTIVE, else 0);
//                  the downstream Hpixel counter advances when count == 19
//   h_active  out  high during the active video phase
//   hsync     out  horizontal sync, asserted only during SYNC
//   pix_tick  out  high on the last system clock of each VGA pixel
//   line_end  out  one-cycle pulse on the last system clock of the line
//
// Configuration macro:
//   HSYNC_ACTIVE_HIGH_EN  defined   -> hsync active-high (reset value 0)
//                         undefined -> hsync active-low  (reset value 1)
//
// All outputs are registered. Their next values are decoded from the
// next-state values, so each output lines up with the state it describes.
// ---------------------------------------------------------------------------
module h_timing_gen #(
    parameter int CLK_PER_PIX = 4,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int REP         = 20
) (
    input  logic       clk,
    input  logic       reset,
    output logic [4:0] count,
    output logic       h_active,
    output logic       hsync,
    output logic       pix_tick,
    output logic       line_end
);

    localparam int DIV_W = (CLK_PER_PIX > 1) ? $clog2(CLK_PER_PIX) : 1;
    localparam int H_MAX01 = (H_ACTIVE > H_FP) ? H_ACTIVE : H_FP;
    localparam int H_MAX23 = (H_SYNC > H_BP) ? H_SYNC : H_BP;
    localparam int H_MAX   = (H_MAX01 > H_MAX23) ? H_MAX01 : H_MAX23;
    localparam int COL_W   = (H_MAX > 1) ? $clog2(H_MAX) : 1;

`ifdef HSYNC_ACTIVE_HIGH_EN
    localparam logic HS_ON = 1'b1;
`else
    localparam logic HS_ON = 1'b0;
`endif
    localparam logic HS_OFF = ~HS_ON;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FRONT  = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BACK   = 2'd3
    } state_t;

    state_t             r_state;
    logic [DIV_W-1:0]   r_div;
    logic [COL_W-1:0]   r_col;
    logic [4:0]         r_count;
    logic               r_h_active;
    logic               r_hsync;
    logic               r_pix_tick;
    logic               r_line_end;

    state_t             w_state_nxt;
    logic [DIV_W-1:0]   w_div_nxt;
    logic [COL_W-1:0]   w_col_nxt;
    logic [COL_W-1:0]   w_phase_last;
    logic [4:0]         w_count_nxt;
    logic               w_pix_end;
    logic               w_phase_end;
    logic               w_h_active_nxt;
    logic               w_hsync_nxt;
    logic               w_pix_tick_nxt;
    logic               w_line_end_nxt;

    // Last column index of the phase currently being generated.
    always_comb begin
        w_phase_last = COL_W'(H_ACTIVE - 1);
        case (r_state)
            ST_ACTIVE: w_phase_last = COL_W'(H_ACTIVE - 1);
            ST_FRONT:  w_phase_last = COL_W'(H_FP - 1);
            ST_SYNC:   w_phase_last = COL_W'(H_SYNC - 1);
            ST_BACK:   w_phase_last = COL_W'(H_BP - 1);
            default:   w_phase_last = COL_W'(H_ACTIVE - 1);
        endcase
    end

    // Next-state, counter and output-decode logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_pix_end      = (r_div == DIV_W'(CLK_PER_PIX - 1));
        w_phase_end    = w_pix_end && (r_col == w_phase_last);

        if (w_pix_end) begin
            w_div_nxt = DIV_W'(0);
        end else begin
            w_div_nxt = r_div + DIV_W'(1);
        end

        if (w_phase_end) begin
            case (r_state)
                ST_ACTIVE: w_state_nxt = ST_FRONT;
                ST_FRONT:  w_state_nxt = ST_SYNC;
                ST_SYNC:   w_state_nxt = ST_BACK;
                ST_BACK:   w_state_nxt = ST_ACTIVE;
                default:   w_state_nxt = ST_ACTIVE;
            endcase
        end else begin
            w_state_nxt = r_state;
        end

        // Column clears on every phase change so each phase starts at 0.
        if (w_phase_end) begin
            w_col_nxt = COL_W'(0);
        end else if (w_pix_end) begin
            w_col_nxt = r_col + COL_W'(1);
        end else begin
            w_col_nxt = r_col;
        end

        // count only runs while staying inside ACTIVE. ACTIVE length is a
        // multiple of REP, so it leaves on REP-1 and the new line starts at 0.
        if ((r_state == ST_ACTIVE) && (w_state_nxt == ST_ACTIVE)) begin
            if (r_count == 5'(REP - 1)) begin
                w_count_nxt = 5'd0;
            end else begin
                w_count_nxt = r_count + 5'd1;
            end
        end else begin
            w_count_nxt = 5'd0;
        end

        w_h_active_nxt = (w_state_nxt == ST_ACTIVE);
        if (w_state_nxt == ST_SYNC) begin
            w_hsync_nxt = HS_ON;
        end else begin
            w_hsync_nxt = HS_OFF;
        end
        w_pix_tick_nxt = (w_div_nxt == DIV_W'(CLK_PER_PIX - 1));
        w_line_end_nxt = (w_state_nxt == ST_BACK) &&
                         (w_div_nxt == DIV_W'(CLK_PER_PIX - 1)) &&
                         (w_col_nxt == COL_W'(H_BP - 1));
    end

    // Phase state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_ACTIVE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Divider, column, count and registered output flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div      <= DIV_W'(0);
            r_col      <= COL_W'(0);
            r_count    <= 5'd0;
            r_h_active <= 1'b1;
            r_hsync    <= HS_OFF;
            r_pix_tick <= 1'b0;
            r_line_end <= 1'b0;
        end else begin
            r_div      <= w_div_nxt;
            r_col      <= w_col_nxt;
            r_count    <= w_count_nxt;
            r_h_active <= w_h_active_nxt;
            r_hsync    <= w_hsync_nxt;
            r_pix_tick <= w_pix_tick_nxt;
            r_line_end <= w_line_end_nxt;
        end
    end

    assign count    = r_count;
    assign h_active = r_h_active;
    assign hsync    = r_hsync;
    assign pix_tick = r_pix_tick;
    assign line_end = r_line_end;

endmodule

// File: tb/tb_h_timing_gen.sv
module tb_h_timing_gen;

`ifdef HSYNC_ACTIVE_HIGH_EN
    localparam logic HS_ON = 1'b1;
`else
    localparam logic HS_ON = 1'b0;
`endif
    localparam logic HS_OFF = ~HS_ON;
    localparam int   LINE   = 3200;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] count;
    logic       h_active;
    logic       hsync;
    logic       pix_tick;
    logic       line_end;

    h_timing_gen dut (
        .clk      (clk),
        .reset    (reset),
        .count    (count),
        .h_active (h_active),
        .hsync    (hsync),
        .pix_tick (pix_tick),
        .line_end (line_end)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] count;
        logic       h_active;
        logic       hsync;
        logic       pix_tick;
        logic       line_end;
    } out_t;

    typedef struct {
        int   t;
        out_t exp;
    } vec_t;

    out_t sb_q[$];
    vec_t tbl[11];
    int   errors = 0;
    int   checks = 0;
    int   tb_t   = 0;
    int   n_hs   = 0;
    int   n_tick = 0;
    int   n_le   = 0;
    int   n_cnz  = 0;

    // Downstream horizontal memory-address counter, as it would sit after the DUT.
    logic [6:0] hpixel = 7'd0;
    always @(posedge clk) begin
        if (reset) hpixel <= 7'd0;
        else if (count == 5'd19) hpixel <= hpixel + 7'd1;
    end

    // Reference behaviour of one line, indexed by cycle within the line.
    function automatic out_t model(int t);
        out_t o;
        o.count    = (t < 2560) ? 5'(t % 20) : 5'd0;
        o.h_active = (t < 2560);
        o.hsync    = (t >= 2624 && t < 3008) ? HS_ON : HS_OFF;
        o.pix_tick = ((t % 4) == 3);
        o.line_end = (t == 3199);
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d actual=%0h expected=%0h", name, tb_t, act, exp);
        end
    endtask

    // One clock: push the expectation at the edge, compare at the falling edge.
    task automatic step();
        out_t e;
        out_t a;
        @(posedge clk);
        if (reset) tb_t = 0;
        else tb_t = (tb_t + 1) % LINE;
        sb_q.push_back(model(tb_t));
        @(negedge clk);
        e = sb_q.pop_front();
        a = {count, h_active, hsync, pix_tick, line_end};
        check("sb_outputs", a, e);
        check("sb_hpixel", hpixel, (tb_t < 2560) ? 7'(tb_t / 20) : 7'd0);
        if (hsync == HS_ON) n_hs++;
        if (pix_tick) n_tick++;
        if (line_end) n_le++;
        if (tb_t >= 2560 && count != 5'd0) n_cnz++;
    endtask

    task automatic run_to(input int target);
        int n;
        n = 0;
        while (tb_t != target && n < 2 * LINE) begin
            step();
            n++;
        end
        if (tb_t != target) begin
            checks++;
            errors++;
            $display("FAIL run_to_timeout t=%0d target=%0d", tb_t, target);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0d", tb_t);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{0,    out_t'({5'd0,  1'b1, HS_OFF, 1'b0, 1'b0})};
        tbl[1]  = '{19,   out_t'({5'd19, 1'b1, HS_OFF, 1'b1, 1'b0})};
        tbl[2]  = '{20,   out_t'({5'd0,  1'b1, HS_OFF, 1'b0, 1'b0})};
        tbl[3]  = '{2559, out_t'({5'd19, 1'b1, HS_OFF, 1'b1, 1'b0})};
        tbl[4]  = '{2560, out_t'({5'd0,  1'b0, HS_OFF, 1'b0, 1'b0})};
        tbl[5]  = '{2623, out_t'({5'd0,  1'b0, HS_OFF, 1'b1, 1'b0})};
        tbl[6]  = '{2624, out_t'({5'd0,  1'b0, HS_ON,  1'b0, 1'b0})};
        tbl[7]  = '{3007, out_t'({5'd0,  1'b0, HS_ON,  1'b1, 1'b0})};
        tbl[8]  = '{3008, out_t'({5'd0,  1'b0, HS_OFF, 1'b0, 1'b0})};
        tbl[9]  = '{3198, out_t'({5'd0,  1'b0, HS_OFF, 1'b0, 1'b0})};
        tbl[10] = '{3199, out_t'({5'd0,  1'b0, HS_OFF, 1'b1, 1'b1})};

        // Reset held for three cycles; the last reset edge starts t = 0.
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;

        // Table walk through the first line.
        for (int i = 0; i < 11; i++) begin
            run_to(tbl[i].t);
            check("tbl_count",    count,    tbl[i].exp.count);
            check("tbl_h_active", h_active, tbl[i].exp.h_active);
            check("tbl_hsync",    hsync,    tbl[i].exp.hsync);
            check("tbl_pix_tick", pix_tick, tbl[i].exp.pix_tick);
            check("tbl_line_end", line_end, tbl[i].exp.line_end);
        end

        // Second full line: per-line totals.
        n_hs = 0; n_tick = 0; n_le = 0; n_cnz = 0;
        for (int i = 0; i < LINE; i++) begin
            step();
            if (i == 0) check("h_active_line_start", h_active, 1'b1);
        end
        check("hsync_on_cycles", n_hs,   384);
        check("pix_tick_pulses", n_tick, 800);
        check("line_end_pulses", n_le,   1);
        check("count_nonzero_blank", n_cnz, 0);

        // Downstream Hpixel wrap behaviour on the third line.
        run_to(19);
        check("hpixel_t19", hpixel, 7'd0);
        step();
        check("hpixel_t20", hpixel, 7'd1);
        run_to(2559);
        check("hpixel_max", hpixel, 7'd127);
        step();
        check("hpixel_wrap", hpixel, 7'd0);

        // One-cycle reset in the middle of SYNC.
        run_to(2800);
        check("hsync_mid_sync", hsync, HS_ON);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("hsync_after_rst",    hsync,    HS_OFF);
        check("count_after_rst",    count,    5'd0);
        check("h_active_after_rst", h_active, 1'b1);
        n_le = 0;
        run_to(3198);
        check("no_spurious_line_end", n_le, 0);
        step();
        check("line_end_after_rst", line_end, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
